seq_divider: RTL and testbench

- Multi-cycle signed radix-2 restoring divider. It acts as the responder for the divide-start handshake issued by the execute stage.
- Accepts 33-bit sign-extended dividend/divisor on a start pulse. Returns quotient and remainder in a 40-bit-padded output word plus a one-cycle done strobe.
- Sits beside the execute stage. Its output feeds the HI/LO write path: LO = tdata[71:40], HI = tdata[31:0].

---
 rtl/cpu_div_pkg.sv | 26 ++
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 148 ++++++++++++++
 tb/tb_seq_divider.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_div_pkg.sv
// Shared constants for the sequential divider: FSM encoding, default widths
// and the LO/HI slice positions of the output word.
package cpu_div_pkg;

   localparam int DEF_OP_W    = 33;
   localparam int DEF_FIELD_W = 40;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      FIX  = ST_FIX,
      DONE = ST_DONE
   } div_state_e;

   // LO takes the quotient field, HI takes the remainder field.
   localparam int LO_MSB = 71;
   localparam int LO_LSB = 40;
   localparam int HI_MSB = 31;
   localparam int HI_LSB = 0;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference only if non-negative.
module div_step
   import cpu_div_pkg::*;
#(
   parameter int OP_W = DEF_OP_W
) (
   input  logic [OP_W:0]   rem_in,
   input  logic [OP_W-1:0] dvsr,
   input  logic            bit_in,
   output logic [OP_W:0]   rem_out,
   output logic            q_bit
);

   logic [OP_W+1:0] shifted;
   logic [OP_W+1:0] trial;

   always_comb begin
      shifted = {rem_in, bit_in};
      trial   = shifted - {2'b00, dvsr};
      // The MSB of the trial difference is its sign: clear means the divisor fit.
      q_bit   = ~trial[OP_W+1];
      rem_out = q_bit ? trial[OP_W:0] : shifted[OP_W:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed radix-2 restoring divider (one quotient bit per cycle).
// Optional macro DIV_ZERO_FAST_EN: a divide-by-zero skips the iteration phase.
module seq_divider
   import cpu_div_pkg::*;
#(
   parameter int OP_W    = DEF_OP_W,
   parameter int FIELD_W = DEF_FIELD_W
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [OP_W-1:0]        s_axis_dividend_tdata,
   input  logic                   s_axis_dividend_tvalid,
   input  logic [OP_W-1:0]        s_axis_divisor_tdata,
   input  logic                   s_axis_divisor_tvalid,
   output logic [2*FIELD_W-1:0]   m_axis_dout_tdata,
   output logic                   m_axis_dout_tvalid,
   output logic                   busy
);

   localparam int CNT_W = $clog2(OP_W);

   div_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [OP_W:0]          rem_q, rem_d;
   logic [OP_W-1:0]        quo_q, quo_d;
   logic [OP_W-1:0]        dvsr_q, dvsr_d;
   logic [OP_W-1:0]        dvnd_q, dvnd_d;
   logic                   qneg_q, qneg_d;
   logic                   rneg_q, rneg_d;
   logic                   dz_q, dz_d;
   logic [2*FIELD_W-1:0]   tdata_q, tdata_d;

   logic                   accept;
   logic [OP_W-1:0]        dvnd_mag;
   logic [OP_W-1:0]        dvsr_mag;
   logic [OP_W:0]          step_rem;
   logic                   step_qbit;
   logic [OP_W-1:0]        q_fix;
   logic [OP_W-1:0]        r_fix;

   div_step #(
      .OP_W (OP_W)
   ) u_step (
      .rem_in  (rem_q),
      .dvsr    (dvsr_q),
      .bit_in  (quo_q[OP_W-1]),
      .rem_out (step_rem),
      .q_bit   (step_qbit)
   );

   always_comb begin
      accept   = (state_q == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;
      dvnd_mag = s_axis_dividend_tdata[OP_W-1] ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
      dvsr_mag = s_axis_divisor_tdata[OP_W-1]  ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;
   end

   // Zero divisor overrides the iteration result so both build variants agree.
   always_comb begin
      q_fix = dz_q ? {OP_W{1'b1}} : (qneg_q ? -quo_q : quo_q);
      r_fix = dz_q ? dvnd_q : (rneg_q ? -rem_q[OP_W-1:0] : rem_q[OP_W-1:0]);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      dvnd_d  = dvnd_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      tdata_d = tdata_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               rem_d  = '0;
               quo_d  = dvnd_mag;
               dvsr_d = dvsr_mag;
               dvnd_d = s_axis_dividend_tdata;
               qneg_d = s_axis_dividend_tdata[OP_W-1] ^ s_axis_divisor_tdata[OP_W-1];
               rneg_d = s_axis_dividend_tdata[OP_W-1];
               dz_d   = (dvsr_mag == '0);
               cnt_d  = CNT_W'(OP_W - 1);
`ifdef DIV_ZERO_FAST_EN
               state_d = (dvsr_mag == '0) ? FIX : CALC;
`else
               state_d = CALC;
`endif
            end
         end
         CALC: begin
            // The quotient register doubles as the dividend shift register.
            rem_d = step_rem;
            quo_d = {quo_q[OP_W-2:0], step_qbit};
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            tdata_d = {FIELD_W'(signed'(q_fix)), FIELD_W'(signed'(r_fix))};
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         dvnd_q  <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         tdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         dvnd_q  <= dvnd_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         tdata_q <= tdata_d;
      end
   end

   always_comb begin
      m_axis_dout_tdata  = tdata_q;
      m_axis_dout_tvalid = (state_q == DONE);
      busy               = (state_q != IDLE);
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed handshake/reset cases plus
// randomized operands against a plain-arithmetic division model.
module tb_seq_divider;
   import cpu_div_pkg::*;

   localparam int OP_W    = 33;
   localparam int FIELD_W = 40;
   localparam int LAT     = OP_W + 2;
`ifdef DIV_ZERO_FAST_EN
   localparam int DZ_LAT  = 2;
`else
   localparam int DZ_LAT  = OP_W + 2;
`endif

   logic                 clk = 1'b0;
   logic                 resetn;
   logic [OP_W-1:0]      dvnd_data;
   logic                 dvnd_valid;
   logic [OP_W-1:0]      dvsr_data;
   logic                 dvsr_valid;
   logic [2*FIELD_W-1:0] dout_data;
   logic                 dout_valid;
   logic                 busy;

   int passes = 0;
   int fails  = 0;
   int total  = 0;

   seq_divider #(.OP_W(OP_W), .FIELD_W(FIELD_W)) dut (
      .clk                    (clk),
      .resetn                 (resetn),
      .s_axis_dividend_tdata  (dvnd_data),
      .s_axis_dividend_tvalid (dvnd_valid),
      .s_axis_divisor_tdata   (dvsr_data),
      .s_axis_divisor_tvalid  (dvsr_valid),
      .m_axis_dout_tdata      (dout_data),
      .m_axis_dout_tvalid     (dout_valid),
      .busy                   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: signed 64-bit division, quotient wrapped to OP_W bits.
   function automatic logic [79:0] model(input logic [32:0] a, input logic [32:0] b);
      longint sa, sb, q, r;
      sa = longint'({{31{a[32]}}, a});
      sb = longint'({{31{b[32]}}, b});
      if (sb == 0) begin
         q = -1;
         r = sa;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
      q = (q <<< 31) >>> 31;
      return {q[39:0], r[39:0]};
   endfunction

   function automatic logic [32:0] rnd_operand();
      logic [31:0] v;
      int s;
      v = $urandom;
      case ($urandom_range(0, 3))
         0: return {v[31], v};
         1: return {1'b0, v};
         2: begin
            s = int'($urandom_range(0, 40)) - 20;
            return 33'(s);
         end
         default: begin
            case (v[1:0])
               2'd0:    return 33'h1_0000_0000;
               2'd1:    return 33'h0_7FFF_FFFF;
               2'd2:    return 33'h1_8000_0000;
               default: return 33'h1_FFFF_FFFF;
            endcase
         end
      endcase
   endfunction

   // One operation: pulse both valids for one cycle, then watch a fixed
   // window for strobe timing, busy shape, result and result hold.
   task automatic run_op(input string tag, input logic [32:0] a, input logic [32:0] b,
                         input int lat, input int intrude_k, output logic [79:0] res);
      logic [79:0] exp;
      logic [79:0] held;
      int          first_k;
      int          strobes;
      bit          busy_ok;
      exp     = model(a, b);
      res     = '0;
      held    = '0;
      first_k = 0;
      strobes = 0;
      busy_ok = 1'b1;
      @(negedge clk);
      dvnd_data  = a;
      dvsr_data  = b;
      dvnd_valid = 1'b1;
      dvsr_valid = 1'b1;
      for (int k = 1; k <= lat + 4; k++) begin
         @(negedge clk);
         if (k == intrude_k) begin
            dvnd_data  = 33'd1000;
            dvsr_data  = 33'd10;
            dvnd_valid = 1'b1;
            dvsr_valid = 1'b1;
         end else begin
            dvnd_valid = 1'b0;
            dvsr_valid = 1'b0;
         end
         if (dout_valid === 1'b1) begin
            strobes++;
            if (first_k == 0) begin
               first_k = k;
               res     = dout_data;
            end
         end
         if (busy !== (k <= lat)) busy_ok = 1'b0;
         if (k == lat + 3) held = dout_data;
      end
      dvnd_valid = 1'b0;
      dvsr_valid = 1'b0;
      check({tag, " latency"}, 80'(first_k), 80'(lat));
      check({tag, " strobes"}, 80'(strobes), 80'd1);
      check({tag, " result"}, res, exp);
      check({tag, " hold"}, held, exp);
      check({tag, " busy"}, 80'(busy_ok), 80'd1);
      $display("op %s: a=%h b=%h lat=%0d strobes=%0d tdata=%h", tag, a, b, first_k, strobes, res);
   endtask

   initial begin
      logic [79:0] r;
      logic [32:0] a, b;
      int          cnt;

      resetn     = 1'b0;
      dvnd_data  = '0;
      dvsr_data  = '0;
      dvnd_valid = 1'b0;
      dvsr_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("reset tvalid", 80'(dout_valid), 80'd0);
      check("reset busy", 80'(busy), 80'd0);
      check("reset tdata", dout_data, 80'd0);
      resetn = 1'b1;
      @(negedge clk);

      run_op("pos 7/2", 33'd7, 33'd2, LAT, 0, r);
      check("pos lo", 80'(r[LO_MSB:LO_LSB]), 80'd3);
      check("pos hi", 80'(r[HI_MSB:HI_LSB]), 80'd1);
      check("pos pad", 80'({r[79:72], r[39:32]}), 80'd0);

      run_op("mixed -7/2", 33'h1_FFFF_FFF9, 33'd2, LAT, 0, r);
      check("mixed q", 80'(r[79:40]), 80'hFF_FFFF_FFFD);
      check("mixed r", 80'(r[39:0]), 80'hFF_FFFF_FFFF);

      run_op("unsigned max/1", 33'h0_FFFF_FFFF, 33'd1, LAT, 0, r);
      check("unsigned lo", 80'(r[LO_MSB:LO_LSB]), 80'hFFFF_FFFF);
      check("unsigned bit72", 80'(r[72]), 80'd0);
      check("unsigned rem", 80'(r[39:0]), 80'd0);

      run_op("div0 -5/0", 33'h1_FFFF_FFFB, 33'd0, DZ_LAT, 0, r);
      check("div0 q", 80'(r[79:40]), 80'hFF_FFFF_FFFF);
      check("div0 r", 80'(r[39:0]), 80'hFF_FFFF_FFFB);

      // Only the dividend is valid: nothing may start.
      cnt = 0;
      @(negedge clk);
      dvnd_data  = 33'd50;
      dvsr_data  = 33'd5;
      dvnd_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 3) dvnd_valid = 1'b0;
         if (busy !== 1'b0 || dout_valid !== 1'b0) cnt++;
      end
      check("one valid idle", 80'(cnt), 80'd0);
      $display("op one-valid: busy/strobe violations=%0d", cnt);

      run_op("intrude 100/7", 33'd100, 33'd7, LAT, 10, r);

      // Reset mid-operation aborts without a strobe and clears the output.
      @(negedge clk);
      dvnd_data  = 33'd100;
      dvsr_data  = 33'd7;
      dvnd_valid = 1'b1;
      dvsr_valid = 1'b1;
      @(negedge clk);
      dvnd_valid = 1'b0;
      dvsr_valid = 1'b0;
      repeat (19) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("midreset tvalid", 80'(dout_valid), 80'd0);
      check("midreset busy", 80'(busy), 80'd0);
      check("midreset tdata", dout_data, 80'd0);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (dout_valid !== 1'b0) cnt++;
      end
      check("midreset no strobe", 80'(cnt), 80'd0);
      $display("op midreset: strobes during reset=%0d", cnt);
      resetn = 1'b1;

      run_op("after reset 9/3", 33'd9, 33'd3, LAT, 0, r);
      check("after reset q", 80'(r[79:40]), 80'd3);
      check("after reset r", 80'(r[39:0]), 80'd0);

      for (int i = 0; i < 24; i++) begin
         a = rnd_operand();
         b = ($urandom_range(0, 9) == 0) ? 33'd0 : rnd_operand();
         run_op($sformatf("rand%0d", i), a, b, (b == 33'd0) ? DZ_LAT : LAT, 0, r);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
